spi_reg_bank: RTL and testbench

- Parametrised SPI-loaded register bank, successor to the fixed sky/floor/leak register block in the raybox-zero top level.
- Holds `NUM_REGS` registers of `REG_W` bits each, written over a slow, asynchronous SPI link.
- Writes are staged in a shadow copy. They become visible together only when the frame-end strobe `load_new` arrives, so the renderer never sees a register change mid-frame.
- It also reports bad frames (wrong length, out-of-range address) and shows which staged writes are still waiting to be applied.

---
 rtl/spi_reg_bank.sv | 147 ++++++++++++++
 tb/tb_spi_reg_bank.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI-loaded register bank. SPI writes land in a staging copy and are
// transferred to the active registers together on the frame-end strobe load_new.
module spi_reg_bank #(
    parameter int                          NUM_REGS   = 3,
    parameter int                          REG_W      = 6,
    parameter int                          ADDR_W     = 2,
    parameter logic [NUM_REGS*REG_W-1:0]   RESET_VALS = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_sclk,
    input  logic                      i_mosi,
    input  logic                      i_ss_n,
    input  logic                      load_new,
    output logic [NUM_REGS*REG_W-1:0] o_regs,
    output logic [NUM_REGS-1:0]       o_pending,
    output logic                      o_err
);

    localparam int FRAME_LEN = ADDR_W + REG_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                   r_mosi_s1, r_mosi_s2;
    logic                   r_ss_s1, r_ss_s2, r_ss_s3;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_LEN-1:0]   r_shift;

    logic                   w_sclk_rise;
    logic                   w_ss_fall;
    logic [ADDR_W-1:0]      w_addr;
    logic [REG_W-1:0]       w_data;
    logic                   w_accept;
    logic                   w_reject;

    // Synchronisers reset to 0 so a select held low across reset never looks like a new falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_ss_s1   <= 1'b0;
            r_ss_s2   <= 1'b0;
            r_ss_s3   <= 1'b0;
        end else begin
            r_sclk_s1 <= i_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_mosi_s1 <= i_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_ss_s1   <= i_ss_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_s3   <= r_ss_s2;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_ss_fall   = r_ss_s3 & ~r_ss_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ss_fall) w_state_next = S_SHIFT;
            S_SHIFT: if (r_ss_s2)   w_state_next = S_CHECK;
            S_CHECK: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit counter saturates one past a full frame so overlong frames stay distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_state == S_IDLE && w_ss_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_state == S_SHIFT && w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_LEN-2:0], r_mosi_s2};
            if (r_cnt != C_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_addr   = r_shift[FRAME_LEN-1 -: ADDR_W];
    assign w_data   = r_shift[REG_W-1:0];
    assign w_accept = (r_state == S_CHECK) && (r_cnt == C_FULL) && (32'(w_addr) < NUM_REGS);
    assign w_reject = (r_state == S_CHECK) && !w_accept;
    assign o_err    = w_reject;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [REG_W-1:0] r_active;
            logic [REG_W-1:0] r_staged;
            logic             r_pending;
            logic             w_hit;

            assign w_hit = w_accept && (w_addr == ADDR_W'(gi));

            // A write accepted on the load_new edge is staged after the old value moves,
            // so it stays pending for the next strobe.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_active  <= RESET_VALS[gi*REG_W +: REG_W];
                    r_staged  <= RESET_VALS[gi*REG_W +: REG_W];
                    r_pending <= 1'b0;
                end else begin
                    if (load_new && r_pending) begin
                        r_active  <= r_staged;
                        r_pending <= 1'b0;
                    end
                    if (w_hit) begin
                        r_staged  <= w_data;
                        r_pending <= 1'b1;
                    end
                end
            end

            assign o_regs[gi*REG_W +: REG_W] = r_active;
            assign o_pending[gi]             = r_pending;
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: SPI frames driven bit by bit, outputs sampled on clk falling edges.
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_sclk = 1'b0;
    logic        i_mosi = 1'b0;
    logic        i_ss_n = 1'b1;
    logic        load_new = 1'b0;
    logic [17:0] o_regs;
    logic [2:0]  o_pending;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    spi_reg_bank #(
        .NUM_REGS  (3),
        .REG_W     (6),
        .ADDR_W    (2),
        .RESET_VALS(18'h0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_sclk   (i_sclk),
        .i_mosi   (i_mosi),
        .i_ss_n   (i_ss_n),
        .load_new (load_new),
        .o_regs   (o_regs),
        .o_pending(o_pending),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_err === 1'b1) err_pulses++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic spi_bits(input int nbits, input logic [15:0] bits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            i_mosi = bits[i];
            repeat (half) @(negedge clk);
            i_sclk = 1'b1;
            repeat (half) @(negedge clk);
            i_sclk = 1'b0;
        end
    endtask

    // Called at a clk falling edge; returns right after select is released.
    task automatic spi_frame(input int nbits, input logic [15:0] bits, input int half);
        $display("frame: %0d bits value=0x%0h half=%0d", nbits, bits, half);
        i_ss_n = 1'b0;
        repeat (2) @(negedge clk);
        spi_bits(nbits, bits, half);
        repeat (half) @(negedge clk);
        i_ss_n = 1'b1;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        $display("load_new: regs=0x%05h pending=%b", o_regs, o_pending);
    endtask

    task automatic test_reset();
        int e0;
        do_reset();
        @(negedge clk);
        checks++; if (o_regs !== 18'h0) begin errors++; $display("FAIL reset_regs got=0x%05h exp=0x00000", o_regs); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%b exp=000", o_pending); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
        e0 = err_pulses;
        i_ss_n = 1'b0;
        repeat (2) @(negedge clk);
        spi_bits(4, 16'h0006, 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        spi_bits(4, 16'h000A, 2);
        repeat (2) @(negedge clk);
        i_ss_n = 1'b1;
        settle();
        $display("mid-frame reset: regs=0x%05h pending=%b", o_regs, o_pending);
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL midreset_err got=%0d exp=0", err_pulses - e0); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL midreset_pending got=%b exp=000", o_pending); end
        pulse_load();
        checks++; if (o_regs !== 18'h0) begin errors++; $display("FAIL midreset_regs got=0x%05h exp=0x00000", o_regs); end
    endtask

    task automatic test_basic_write();
        int e0;
        e0 = err_pulses;
        @(negedge clk);
        spi_frame(8, 16'h006A, 2);
        settle();
        checks++; if (o_pending !== 3'b010) begin errors++; $display("FAIL basic_pending got=%b exp=010", o_pending); end
        checks++; if (o_regs !== 18'h0) begin errors++; $display("FAIL basic_regs_before got=0x%05h exp=0x00000", o_regs); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL basic_err got=%0d exp=0", err_pulses - e0); end
        pulse_load();
        checks++; if (o_regs !== {6'h00, 6'h2A, 6'h00}) begin errors++; $display("FAIL basic_regs_after got=0x%05h exp=0x%05h", o_regs, {6'h00, 6'h2A, 6'h00}); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL basic_pending_after got=%b exp=000", o_pending); end
    endtask

    task automatic test_bad_frames();
        int e0;
        e0 = err_pulses;
        spi_frame(7, 16'h0020, 2);
        settle();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL short_err got=%0d exp=1", err_pulses - e0); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL short_pending got=%b exp=000", o_pending); end
        e0 = err_pulses;
        spi_frame(9, 16'h0055, 2);
        settle();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL long_err got=%0d exp=1", err_pulses - e0); end
        e0 = err_pulses;
        spi_frame(8, 16'h00C1, 2);
        settle();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL addr3_err got=%0d exp=1", err_pulses - e0); end
        e0 = err_pulses;
        spi_frame(0, 16'h0000, 2);
        settle();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL zero_bit_err got=%0d exp=1", err_pulses - e0); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL bad_pending got=%b exp=000", o_pending); end
        pulse_load();
        checks++; if (o_regs !== {6'h00, 6'h2A, 6'h00}) begin errors++; $display("FAIL bad_regs got=0x%05h exp=0x%05h", o_regs, {6'h00, 6'h2A, 6'h00}); end
    endtask

    task automatic test_overwrite();
        do_reset();
        @(negedge clk);
        spi_frame(8, 16'h0011, 2);
        settle();
        spi_frame(8, 16'h003F, 2);
        settle();
        spi_frame(8, 16'h0085, 2);
        settle();
        checks++; if (o_pending !== 3'b101) begin errors++; $display("FAIL ovw_pending got=%b exp=101", o_pending); end
        checks++; if (o_regs !== 18'h0) begin errors++; $display("FAIL ovw_idle_regs got=0x%05h exp=0x00000", o_regs); end
        pulse_load();
        checks++; if (o_regs !== {6'h05, 6'h00, 6'h3F}) begin errors++; $display("FAIL ovw_regs got=0x%05h exp=0x%05h", o_regs, {6'h05, 6'h00, 6'h3F}); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL ovw_pending_after got=%b exp=000", o_pending); end
    endtask

    task automatic test_simultaneous();
        int e0;
        do_reset();
        @(negedge clk);
        e0 = err_pulses;
        spi_frame(8, 16'h0001, 2);
        settle();
        spi_frame(8, 16'h0087, 2);
        // Select rose at this falling edge; the frame sits in CHECK during the fourth clk edge.
        repeat (3) @(negedge clk);
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        $display("simultaneous load: regs=0x%05h pending=%b", o_regs, o_pending);
        checks++; if (o_regs[5:0] !== 6'h01) begin errors++; $display("FAIL sim_reg0 got=0x%02h exp=0x01", o_regs[5:0]); end
        checks++; if (o_regs[17:12] !== 6'h00) begin errors++; $display("FAIL sim_reg2 got=0x%02h exp=0x00", o_regs[17:12]); end
        checks++; if (o_pending !== 3'b100) begin errors++; $display("FAIL sim_pending got=%b exp=100", o_pending); end
        settle();
        pulse_load();
        checks++; if (o_regs[17:12] !== 6'h07) begin errors++; $display("FAIL sim_reg2_next got=0x%02h exp=0x07", o_regs[17:12]); end
        checks++; if (o_pending !== 3'b000) begin errors++; $display("FAIL sim_pending_next got=%b exp=000", o_pending); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL sim_err got=%0d exp=0", err_pulses - e0); end
    endtask

    task automatic test_back_to_back();
        int e0;
        do_reset();
        @(negedge clk);
        e0 = err_pulses;
        spi_frame(8, 16'h0015, 2);
        repeat (2) @(negedge clk);
        spi_frame(8, 16'h006B, 2);
        repeat (2) @(negedge clk);
        spi_frame(8, 16'h00BC, 2);
        settle();
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL b2b_err got=%0d exp=0", err_pulses - e0); end
        checks++; if (o_pending !== 3'b111) begin errors++; $display("FAIL b2b_pending got=%b exp=111", o_pending); end
        pulse_load();
        checks++; if (o_regs !== {6'h3C, 6'h2B, 6'h15}) begin errors++; $display("FAIL b2b_regs got=0x%05h exp=0x%05h", o_regs, {6'h3C, 6'h2B, 6'h15}); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_bad_frames();
        test_overwrite();
        test_simultaneous();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
